// File: rtl/intr_entry_sequencer_pkg.sv
// Shared interrupt definitions: exception codes, SPR numbers, MSR bits and the
// sequencer state encoding used by the interrupt entry / rfi logic.
package intr_entry_sequencer_pkg;

  localparam int EXC_W_DEF = 4;

  typedef enum logic [EXC_W_DEF-1:0] {
    EXC_NONE  = 4'd0,
    EXC_DSI   = 4'd1,
    EXC_ISI   = 4'd2,
    EXC_DMISS = 4'd3,
    EXC_IMISS = 4'd4,
    EXC_TRAP  = 4'd5,
    EXC_PRIV  = 4'd6,
    EXC_ILLE  = 4'd7,
    EXC_SC    = 4'd8,
    EXC_DEV0  = 4'd9,
    EXC_DEV1  = 4'd10
  } excep_code_e;

  localparam logic [9:0] SPRN_SRR0 = 10'd26;
  localparam logic [9:0] SPRN_SRR1 = 10'd27;
  localparam logic [9:0] SPRN_DEAR = 10'd61;

  // Little-endian indices of the MSR bits cleared on interrupt entry.
  localparam int MSR_FP_BIT = 16;
  localparam int MSR_EE_BIT = 15;
  localparam int MSR_PR_BIT = 14;
  localparam logic [31:0] MSR_CLR_MASK_DEF =
    (32'd1 << MSR_FP_BIT) | (32'd1 << MSR_EE_BIT) | (32'd1 << MSR_PR_BIT);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_DRAIN = 4'd1;
  localparam logic [3:0] ST_SAVE0 = 4'd2;
  localparam logic [3:0] ST_SAVE1 = 4'd3;
  localparam logic [3:0] ST_SAVE2 = 4'd4;
  localparam logic [3:0] ST_ENTER = 4'd5;
  localparam logic [3:0] ST_RFI0  = 4'd6;
  localparam logic [3:0] ST_RFI1  = 4'd7;
  localparam logic [3:0] ST_RFI2  = 4'd8;

  // Data-side faults also record the faulting effective address in DEAR.
  function automatic logic needs_dear(input logic [EXC_W_DEF-1:0] code);
    return (code == EXC_DSI) || (code == EXC_DMISS);
  endfunction

endpackage

// File: rtl/intr_entry_sequencer_drain_timer.sv
// Saturating drain counter: counts cycles spent waiting for the pipeline to
// empty and flags when the forced-entry limit is reached.
module intr_drain_timer #(
  parameter int DRAIN_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic done
);

  localparam int CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  logic [CW-1:0] count;

  assign done = (count == CW'(DRAIN_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/intr_entry_sequencer.sv
// Interrupt entry and rfi sequencer: drains the pipe, saves context into
// SRR0/SRR1/DEAR, vectors the PC and restores state on rfi.
module intr_entry_sequencer
  import intr_entry_sequencer_pkg::*;
#(
  parameter int          EXC_W        = EXC_W_DEF,
  parameter int          DRAIN_MAX    = 8,
  parameter logic [31:0] MSR_CLR_MASK = MSR_CLR_MASK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [EXC_W-1:0] excep_code,
  input  logic [31:0]      intr_entry_addr,
  input  logic [31:0]      epc,
  input  logic [31:0]      fault_addr,
  input  logic [31:0]      msr_in,
  input  logic             pipe_empty,
  input  logic             rfi_req,
  output logic [9:0]       spr_addr,
  output logic [31:0]      spr_wd,
  output logic             spr_wr,
  input  logic [31:0]      spr_rd,
  output logic             stall,
  output logic             flush,
  output logic             pc_wr,
  output logic [31:0]      pc_wd,
  output logic             msr_wr,
  output logic [31:0]      msr_wd,
  output logic             ack,
  output logic             rfi_ack,
  output logic             busy
);

  logic [3:0]       state;
  logic [3:0]       state_d;
  logic [EXC_W-1:0] code_q;
  logic [31:0]      epc_q;
  logic [31:0]      fault_q;
  logic [31:0]      msr_q;
  logic [31:0]      entry_q;
  logic [31:0]      pc_buf;
  logic [31:0]      msr_buf;
  logic             drain_done;
  logic             drain_exit;
  logic             code_is_sc;
  logic             code_has_dear;

  assign code_is_sc    = (code_q == EXC_W'(EXC_SC));
  assign code_has_dear = needs_dear(EXC_W_DEF'(code_q));
  assign drain_exit    = (state == ST_DRAIN) && (pipe_empty || drain_done);

  intr_drain_timer #(.DRAIN_MAX(DRAIN_MAX)) u_drain_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_DRAIN),
    .clear (drain_exit),
    .done  (drain_done)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (excep_code != '0) state_d = ST_DRAIN;
        else if (rfi_req)     state_d = ST_RFI0;
      end
      ST_DRAIN: if (drain_exit) state_d = ST_SAVE0;
      ST_SAVE0: state_d = ST_SAVE1;
      ST_SAVE1: state_d = code_has_dear ? ST_SAVE2 : ST_ENTER;
      ST_SAVE2: state_d = ST_ENTER;
      ST_ENTER: state_d = ST_IDLE;
      ST_RFI0:  state_d = ST_RFI1;
      ST_RFI1:  state_d = ST_RFI2;
      ST_RFI2:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      code_q  <= '0;
      epc_q   <= '0;
      fault_q <= '0;
      msr_q   <= '0;
      entry_q <= '0;
      pc_buf  <= '0;
      msr_buf <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && excep_code != '0) begin
        code_q  <= excep_code;
        epc_q   <= epc;
        fault_q <= fault_addr;
        msr_q   <= msr_in;
        entry_q <= intr_entry_addr;
      end
      if (state == ST_RFI0) pc_buf  <= spr_rd;
      if (state == ST_RFI1) msr_buf <= spr_rd;
    end
  end

  // Outputs are forced low while rst is high so an aborted save never lands.
  always_comb begin
    spr_addr = '0;
    spr_wd   = '0;
    spr_wr   = 1'b0;
    flush    = 1'b0;
    pc_wr    = 1'b0;
    pc_wd    = '0;
    msr_wr   = 1'b0;
    msr_wd   = '0;
    ack      = 1'b0;
    rfi_ack  = 1'b0;
    if (!rst) begin
      case (state)
        ST_DRAIN: flush = 1'b1;
        ST_SAVE0: begin
          spr_wr   = 1'b1;
          spr_addr = SPRN_SRR0;
          spr_wd   = code_is_sc ? (epc_q + 32'd4) : epc_q;
        end
        ST_SAVE1: begin
          spr_wr   = 1'b1;
          spr_addr = SPRN_SRR1;
          spr_wd   = msr_q;
        end
        ST_SAVE2: begin
          spr_wr   = 1'b1;
          spr_addr = SPRN_DEAR;
          spr_wd   = fault_q;
        end
        ST_ENTER: begin
          pc_wr  = 1'b1;
          pc_wd  = entry_q;
          msr_wr = 1'b1;
          msr_wd = msr_q & ~MSR_CLR_MASK;
          ack    = 1'b1;
        end
        ST_RFI0: spr_addr = SPRN_SRR0;
        ST_RFI1: spr_addr = SPRN_SRR1;
        ST_RFI2: begin
          pc_wr   = 1'b1;
          pc_wd   = {pc_buf[31:2], 2'b00};
          msr_wr  = 1'b1;
          msr_wd  = msr_buf;
          rfi_ack = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != ST_IDLE) && !rst;
  assign stall = busy;

endmodule

// File: tb/tb_intr_entry_sequencer.sv
// Scoreboard bench for intr_entry_sequencer: expected SPR writes, entry and rfi
// events are queued with their cycle stamps and matched as the DUT emits them.
module tb_intr_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  excep_code;
  logic [31:0] intr_entry_addr, epc, fault_addr, msr_in;
  logic        pipe_empty, rfi_req;
  logic [9:0]  spr_addr;
  logic [31:0] spr_wd, spr_rd, pc_wd, msr_wd;
  logic        spr_wr, stall, flush, pc_wr, msr_wr, ack, rfi_ack, busy;

  typedef struct {
    int          kind;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] data2;
    int          cyc;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  logic [31:0] srr0_m = 32'h0, srr1_m = 32'h0, dear_m = 32'h0;

  intr_entry_sequencer dut (
    .clk(clk), .rst(rst), .excep_code(excep_code), .intr_entry_addr(intr_entry_addr),
    .epc(epc), .fault_addr(fault_addr), .msr_in(msr_in), .pipe_empty(pipe_empty),
    .rfi_req(rfi_req), .spr_addr(spr_addr), .spr_wd(spr_wd), .spr_wr(spr_wr),
    .spr_rd(spr_rd), .stall(stall), .flush(flush), .pc_wr(pc_wr), .pc_wd(pc_wd),
    .msr_wr(msr_wr), .msr_wd(msr_wd), .ack(ack), .rfi_ack(rfi_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Simple SPR file standing in for the real one.
  always @(posedge clk) begin
    if (spr_wr) begin
      if (spr_addr == 10'd26) srr0_m <= spr_wd;
      if (spr_addr == 10'd27) srr1_m <= spr_wd;
      if (spr_addr == 10'd61) dear_m <= spr_wd;
    end
  end

  assign spr_rd = (spr_addr == 10'd26) ? srr0_m :
                  (spr_addr == 10'd27) ? srr1_m :
                  (spr_addr == 10'd61) ? dear_m : 32'h0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: every strobe cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (spr_wr || pc_wr || msr_wr || ack || rfi_ack) begin
      ev_t o, e;
      o.addr = spr_addr;
      o.cyc  = cycle;
      if (spr_wr && !pc_wr && !msr_wr && !ack && !rfi_ack) begin
        o.kind = 1; o.data = spr_wd; o.data2 = 32'h0;
      end else if (pc_wr && msr_wr && ack && !spr_wr && !rfi_ack) begin
        o.kind = 2; o.data = pc_wd; o.data2 = msr_wd;
      end else if (pc_wr && msr_wr && rfi_ack && !spr_wr && !ack) begin
        o.kind = 3; o.data = pc_wd; o.data2 = msr_wd;
      end else begin
        o.kind = 4; o.data = 32'h0; o.data2 = 32'h0;
      end
      if (sb.size() == 0) begin
        check_output("unexpected_event", o.kind, 0);
      end else begin
        e = sb.pop_front();
        check_output("event_kind", o.kind, e.kind);
        check_output("event_cycle", o.cyc, e.cyc);
        if (e.kind == 1) check_output("spr_addr", {22'h0, o.addr}, {22'h0, e.addr});
        check_output("event_data", o.data, e.data);
        check_output("event_data2", o.data2, e.data2);
      end
    end
  end

  task automatic push_ev(input int kind, input logic [9:0] addr, input logic [31:0] d1,
                         input logic [31:0] d2, input int cyc);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = d1; e.data2 = d2; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic push_exc(input int start, input logic [3:0] code, input logic [31:0] epc_v,
                          input logic [31:0] fa_v, input logic [31:0] msr_v,
                          input logic [31:0] entry_v, input int d, output int enter_cyc);
    push_ev(1, 10'd26, (code == 4'd8) ? epc_v + 32'd4 : epc_v, 32'h0, start + d);
    push_ev(1, 10'd27, msr_v, 32'h0, start + d + 1);
    if (code == 4'd1 || code == 4'd3) begin
      push_ev(1, 10'd61, fa_v, 32'h0, start + d + 2);
      enter_cyc = start + d + 3;
    end else begin
      enter_cyc = start + d + 2;
    end
    push_ev(2, 10'd0, entry_v, msr_v & 32'hFFFE_3FFF, enter_cyc);
  endtask

  // late=1: the code appears only once the rfi sequence has started.
  task automatic apply_stimulus(input logic [3:0] code, input bit do_rfi, input bit late,
                                input logic [31:0] epc_v, input logic [31:0] fa_v,
                                input logic [31:0] msr_v, input logic [31:0] entry_v,
                                input int n_low);
    int d, c0, ent, flush_cnt;
    bit ack_seen, rfi_seen, done;
    d = (n_low + 1 > 8) ? 8 : n_low + 1;
    c0 = cycle + 1;
    flush_cnt = 0; ack_seen = 0; rfi_seen = 0; done = 0;
    if (code != 4'd0 && !late) begin
      push_exc(c0, code, epc_v, fa_v, msr_v, entry_v, d, ent);
      if (do_rfi) push_ev(3, 10'd0, (code == 4'd8 ? epc_v + 32'd4 : epc_v) & 32'hFFFF_FFFC,
                          msr_v, ent + 4);
    end else begin
      push_ev(3, 10'd0, srr0_m & 32'hFFFF_FFFC, srr1_m, c0 + 2);
      if (late) push_exc(c0 + 4, code, epc_v, fa_v, msr_v, entry_v, d, ent);
    end
    excep_code = late ? 4'd0 : code;
    rfi_req = do_rfi;
    epc = epc_v; fault_addr = fa_v; msr_in = msr_v; intr_entry_addr = entry_v;
    pipe_empty = (n_low == 0);
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      if (flush) flush_cnt++;
      if (ack) begin ack_seen = 1; excep_code = 4'd0; end
      if (rfi_ack) begin rfi_seen = 1; rfi_req = 1'b0; end
      if (late && k == 1) excep_code = code;
      pipe_empty = (k > n_low);
      done = (code == 4'd0 || ack_seen) && (!do_rfi || rfi_seen);
    end
    if (!done) check_output("timeout", 32'd0, 32'd1);
    if (code != 4'd0) check_output("drain_len", flush_cnt, d);
    excep_code = 4'd0; rfi_req = 1'b0;
    @(negedge clk);
    check_output("idle_after", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int c0;
    rst = 1'b1; excep_code = 4'd0; rfi_req = 1'b0; pipe_empty = 1'b0;
    epc = 32'h0; fault_addr = 32'h0; msr_in = 32'h0; intr_entry_addr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_outs", {31'h0, |{spr_addr, spr_wd, spr_wr, stall, flush, pc_wr,
                 pc_wd, msr_wr, msr_wd, ack, rfi_ack, busy}}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus(4'd8, 0, 0, 32'h0000_0100, 32'h0, 32'h0002_8000, 32'hFFFF_0800, 0);
    apply_stimulus(4'd1, 0, 0, 32'h0000_3000, 32'hDEAD_BEE0, 32'h0000_8000, 32'h0000_0300, 2);
    apply_stimulus(4'd9, 0, 0, 32'h0000_4000, 32'h0, 32'h0001_F000, 32'h0000_0900, 100);
    srr0_m = 32'h0000_2003; srr1_m = 32'h0000_8000;
    apply_stimulus(4'd0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    apply_stimulus(4'd6, 1, 0, 32'h0000_5004, 32'h0, 32'h0000_C000, 32'h0000_0700, 1);
    srr0_m = 32'h0000_6009; srr1_m = 32'h0000_1234;
    apply_stimulus(4'd5, 1, 1, 32'h0000_7000, 32'h0, 32'h0000_8000, 32'h0000_0700, 0);
    apply_stimulus(4'd8, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 32'h0000_0C00, 0);
    apply_stimulus(4'd3, 0, 0, 32'h0000_8888, 32'h1234_5678, 32'h0000_4000, 32'h0000_1100, 0);

    // Reset during SAVE1 of a DSI entry: SRR0 lands, SRR1/DEAR/ack never do.
    srr1_m = 32'h0000_5555; dear_m = 32'h0000_AAAA;
    c0 = cycle + 1;
    push_ev(1, 10'd26, 32'h0000_9000, 32'h0, c0 + 1);
    excep_code = 4'd1; epc = 32'h0000_9000; fault_addr = 32'hBAD0_0000;
    msr_in = 32'h0000_8000; intr_entry_addr = 32'h0000_0300; pipe_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("rst_save1_wr", {31'h0, spr_wr}, 32'h0);
    excep_code = 4'd0;
    @(negedge clk);
    check_output("rst_outs", {31'h0, |{spr_addr, spr_wd, spr_wr, stall, flush, pc_wr,
                 pc_wd, msr_wr, msr_wd, ack, rfi_ack, busy}}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_srr1_kept", srr1_m, 32'h0000_5555);
    check_output("rst_dear_kept", dear_m, 32'h0000_AAAA);
    check_output("rst_idle", {31'h0, busy}, 32'h0);

    check_output("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
